// File: rtl/counter_uart_tx_pkg.sv
// Shared definitions for the counter UART transmitter: FSM encoding and frame geometry.
package uart_tx_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and pulses bit_done
// on the last cycle of each bit period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Clearing while stopped makes the first period after acceptance a full bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_done = run && (cnt == TERM);

endmodule

// File: rtl/counter_uart_tx.sv
// 8N1 UART transmitter for the demo counter value. One byte is accepted per frame
// via valid/ready; the line is driven from a register and idles high.
module counter_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy
);

    // Handshake: a byte transfers on a rising edge where data_valid and data_ready
    // are both high; data_ready depends only on the registered state.
    uart_state_e          state;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           bit_idx;
    logic                 bit_done;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (state != IDLE),
        .bit_done (bit_done)
    );

    assign data_ready = (state == IDLE);
    assign busy       = ~data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift_q <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (data_valid) begin
                        shift_q <= data_in;
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        tx    <= shift_q[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    // tx is loaded with the bit that becomes bit 0 after this shift.
                    if (bit_done) begin
                        shift_q <= shift_q >> 1;
                        tx      <= shift_q[1];
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        tx    <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_uart_tx.sv
// Directed bench for counter_uart_tx with CLKS_PER_BIT=4; tx is sampled at mid-bit.
module tb_counter_uart_tx;

    localparam int N = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       tx;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic       mon_en = 1'b0;
    int         frame_err = 0;

    counter_uart_tx #(
        .CLKS_PER_BIT(N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .busy       (busy)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called just after the accepting edge; ends just after edge k+10N.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            tick();
            tick();
            chk($sformatf("%s_tx_bit%0d", tag, i), {31'd0, tx}, {31'd0, f[i]});
            tick();
            chk($sformatf("%s_busy_bit%0d", tag, i), {31'd0, busy}, 32'd1);
            tick();
        end
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_ready_end"}, {31'd0, data_ready}, 32'd1);
    endtask

    // Line decoder used during the counter sweep; samples on the falling edge.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = tx;
                end
                repeat (4) @(negedge clk);
                if (tx !== 1'b1) frame_err++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        int n;
        int budget;
        int bad_idle;
        int nrx;

        rst_n      = 1'b0;
        data_valid = 1'b0;
        data_in    = 8'h00;

        // Reset held for two cycles
        tick();
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ready", {31'd0, data_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        bad_idle = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx !== 1'b1 || data_ready !== 1'b1 || busy !== 1'b0) bad_idle++;
        end
        chk("idle_after_rst", bad_idle, 0);

        // Single byte 0xA5, one-cycle valid
        data_in    = 8'hA5;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        chk("a5_ready_low", {31'd0, data_ready}, 32'd0);
        check_frame(8'hA5, "a5");

        // Back-to-back: valid held high, 0x00 then 0xFF
        data_in    = 8'h00;
        data_valid = 1'b1;
        tick();
        data_in = 8'hFF;
        check_frame(8'h00, "b2b0");
        chk("b2b_mark", {31'd0, tx}, 32'd1);
        tick();
        data_valid = 1'b0;
        chk("b2b_second_start", {31'd0, tx}, 32'd0);
        check_frame(8'hFF, "b2b1");

        // Back-pressure: new data offered mid-frame must wait
        data_in    = 8'h81;
        data_valid = 1'b1;
        tick();
        data_in = 8'h3C;
        check_frame(8'h81, "bp81");
        tick();
        data_valid = 1'b0;
        check_frame(8'h3C, "bp3c");

        // Reset during data bit 3 of 0x55
        data_in    = 8'h55;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        repeat (17) tick();
        chk("mid_bit3", {31'd0, tx}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", {31'd0, tx}, 32'd1);
        chk("mid_rst_ready", {31'd0, data_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, tx}, 32'd1);
        data_in    = 8'h0F;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        check_frame(8'h0F, "rx0f");

        // Counter sweep 0..255 then wrap to 0, valid held high
        mon_en     = 1'b1;
        n          = 0;
        budget     = 0;
        data_in    = 8'd0;
        data_valid = 1'b1;
        while (n < 257 && budget < 12000) begin
            if (data_ready) begin
                exp_q.push_back(data_in);
                n++;
                tick();
                data_in = data_in + 8'd1;
                if (n == 257) data_valid = 1'b0;
            end else begin
                tick();
            end
            budget++;
        end
        data_valid = 1'b0;
        chk("sweep_accepts", n, 257);
        repeat (50) tick();
        mon_en = 1'b0;
        nrx = rx_q.size();
        chk("sweep_rx_count", nrx, 257);
        chk("sweep_frame_err", frame_err, 0);
        for (int i = 0; i < 257; i++) begin
            if (rx_q.size() > 0 && exp_q.size() > 0) begin
                chk($sformatf("sweep_byte%0d", i), {24'd0, rx_q.pop_front()},
                    {24'd0, exp_q.pop_front()});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
